// File: rtl/decode_pkg.sv
// Shared definitions for the decode/issue stage.
//   - Architectural sizes (register count, data width, opcode width).
//   - Opcode constants, including the NOP that is issued for illegal opcodes.
//   - Instruction field positions and the decoded-instruction struct.
//   - decode_instr(): splits an instruction word into its fields and
//     classifies which operands it reads and whether it writes rd.
package decode_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int OPC_W    = 8;
    localparam int REG_AW   = 5;
    localparam int IMM_W    = 14;
    localparam int INSTR_W  = 32;

    localparam logic [OPC_W-1:0] OPC_ADD      = 8'h00;
    localparam logic [OPC_W-1:0] OPC_SUB      = 8'h01;
    localparam logic [OPC_W-1:0] OPC_MUL      = 8'h02;
    localparam logic [OPC_W-1:0] OPC_MEM_BASE = 8'h10;
    localparam logic [OPC_W-1:0] OPC_MEM_LAST = 8'h1F;
    localparam logic [OPC_W-1:0] OPC_BEQ      = 8'h30;
    localparam logic [OPC_W-1:0] OPC_JUMP     = 8'h31;
    localparam logic [OPC_W-1:0] OPC_TLBWRITE = 8'h32;
    localparam logic [OPC_W-1:0] OPC_IRET     = 8'h33;
    localparam logic [OPC_W-1:0] OPC_NOP      = 8'hFF;

    // Field positions: opcode[31:24] rd[23:19] ra[18:14] rb[13:9] imm[13:0].
    // rb and imm overlap; which one is meaningful depends on the opcode.
    localparam int OPC_LSB = 24;
    localparam int RD_LSB  = 19;
    localparam int RA_LSB  = 14;
    localparam int RB_LSB  = 9;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;     // OPC_NOP when the raw opcode is illegal
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [IMM_W-1:0]  imm;
        logic              uses_rb;
        logic              writes_rd;
    } decoded_t;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] opcode);
        return (opcode >= OPC_MEM_BASE) && (opcode <= OPC_MEM_LAST);
    endfunction

    function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        d.opcode    = instr[OPC_LSB +: OPC_W];
        d.rd        = instr[RD_LSB  +: REG_AW];
        d.ra        = instr[RA_LSB  +: REG_AW];
        d.rb        = instr[RB_LSB  +: REG_AW];
        d.imm       = instr[IMM_LSB +: IMM_W];
        d.uses_rb   = 1'b0;
        d.writes_rd = 1'b0;
        case (d.opcode) inside
            OPC_ADD, OPC_SUB, OPC_MUL: begin
                d.uses_rb   = 1'b1;
                d.writes_rd = 1'b1;
            end
            [OPC_MEM_BASE:OPC_MEM_LAST]:      ;  // ra + imm, result not written here
            OPC_BEQ, OPC_TLBWRITE, OPC_IRET:  d.uses_rb = 1'b1;
            OPC_JUMP:                         ;  // ra only
            default:                          d.opcode = OPC_NOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 architectural register file for the decode/issue stage.
//   clock, reset_c      : rising-edge clock, synchronous active-low reset
//   rd_addr1/rd_data1   : read port 1 (combinational)
//   rd_addr2/rd_data2   : read port 2 (combinational)
//   wr_en/wr_addr/wr_data : write port, written at the end of the cycle
// R0 always reads zero and ignores writes. A read of the register being
// written in the same cycle returns the write data (write-through bypass).
module decode_regfile
    import decode_pkg::*;
(
    input  logic              clock,
    input  logic              reset_c,
    input  logic [REG_AW-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // NOTE: the array is cleared entry by entry because reset must leave every
    // architectural register at zero; a reset-less memory would power up X.
    always_ff @(posedge clock) begin
        if (!reset_c) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == '0)                    ? '0      :
                      (wr_live && (rd_addr1 == wr_addr))  ? wr_data :
                                                            regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0)                    ? '0      :
                      (wr_live && (rd_addr2 == wr_addr))  ? wr_data :
                                                            regs[rd_addr2];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage in front of the ALU.
//   clock, reset_c : rising-edge clock, synchronous active-low reset
//   fetch_valid, fetch_instr : instruction offered by fetch
//   decode_ready   : combinational accept; transfer when fetch_valid && decode_ready
//   stall_alu      : ALU stalled, hold everything on the issue side
//   dec_val1, dec_val2, dec_instr : registered operands/opcode to the ALU
//   wb_data, wb_en : ALU result returning for writeback
//   branch_taken   : ALU redirect, squash the wrong-path work
// Two tracking stages follow each instruction: issue_rd/issue_writes for the
// instruction on the issue outputs, and wb_rd/wb_valid for the one in the ALU
// whose result may arrive on wb_data this cycle.
module decode_issue
    import decode_pkg::*;
(
    input  logic               clock,
    input  logic               reset_c,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] fetch_instr,
    output logic               decode_ready,
    input  logic               stall_alu,
    output logic [DATA_W-1:0]  dec_val1,
    output logic [DATA_W-1:0]  dec_val2,
    output logic [OPC_W-1:0]   dec_instr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               wb_en,
    input  logic               branch_taken
);

    decoded_t          dec;
    logic              is_legal;
    logic              hazard;
    logic              accept;

    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic [REG_AW-1:0] issue_rd;
    logic              issue_writes;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_valid;

    logic [DATA_W-1:0] nxt_val1;
    logic [DATA_W-1:0] nxt_val2;
    logic [OPC_W-1:0]  nxt_instr;
    logic [REG_AW-1:0] nxt_rd;
    logic              nxt_writes;

    assign dec      = decode_instr(fetch_instr);
    assign is_legal = (dec.opcode != OPC_NOP);

    decode_regfile u_regfile (
        .clock    (clock),
        .reset_c  (reset_c),
        .rd_addr1 (dec.ra),
        .rd_data1 (rd_data1),
        .rd_addr2 (dec.rb),
        .rd_data2 (rd_data2),
        .wr_en    (wb_en && wb_valid),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // The producer on the issue outputs has no result yet; the bypass only
    // covers it one cycle later, so a matching source costs one bubble.
    assign hazard = fetch_valid && issue_writes && (issue_rd != '0) &&
                    ((is_legal && (dec.ra == issue_rd)) ||
                     (dec.uses_rb && (dec.rb == issue_rd)));

    // Priority: reset, then ALU stall, then redirect (always consumes), then hazard.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        decode_ready = 1'b0;
        if (reset_c && !stall_alu) begin
            decode_ready = branch_taken || !hazard;
        end
    end

    assign accept = fetch_valid && decode_ready && !branch_taken;

    always_comb begin
        nxt_instr  = OPC_NOP;
        nxt_val1   = '0;
        nxt_val2   = '0;
        nxt_rd     = '0;
        nxt_writes = 1'b0;
        if (accept && is_legal) begin
            nxt_instr  = dec.opcode;
            nxt_val1   = rd_data1;
            nxt_rd     = dec.rd;
            nxt_writes = dec.writes_rd;
            if (is_mem_op(dec.opcode)) begin
                nxt_val2 = {{(DATA_W-IMM_W){dec.imm[IMM_W-1]}}, dec.imm};
            end else if (dec.uses_rb) begin
                nxt_val2 = rd_data2;
            end
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_c) begin
            dec_val1     <= '0;
            dec_val2     <= '0;
            dec_instr    <= OPC_NOP;
            issue_rd     <= '0;
            issue_writes <= 1'b0;
            wb_rd        <= '0;
            wb_valid     <= 1'b0;
        end else if (!stall_alu) begin
            dec_val1     <= nxt_val1;
            dec_val2     <= nxt_val2;
            dec_instr    <= nxt_instr;
            issue_rd     <= nxt_rd;
            issue_writes <= nxt_writes;
            wb_rd        <= issue_rd;
            // A redirect kills the instruction now entering the ALU.
            wb_valid     <= issue_writes && !branch_taken;
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue. Each vector is one clock cycle:
// inputs are applied, decode_ready is checked before the edge, and the
// registered issue outputs are checked just after the edge.
module tb_decode_issue;

    logic        clock;
    logic        reset_c;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        decode_ready;
    logic        stall_alu;
    logic [31:0] dec_val1;
    logic [31:0] dec_val2;
    logic [7:0]  dec_instr;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        branch_taken;

    int tests;
    int fails;

    typedef struct {
        bit          rst;
        bit          fv;
        logic [31:0] instr;
        bit          stall;
        bit          br;
        bit          wen;
        logic [31:0] wdata;
        bit          e_ready;
        logic [7:0]  e_op;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
    } vec_t;

    vec_t vt[$];

    decode_issue dut (
        .clock        (clock),
        .reset_c      (reset_c),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .decode_ready (decode_ready),
        .stall_alu    (stall_alu),
        .dec_val1     (dec_val1),
        .dec_val2     (dec_val2),
        .dec_instr    (dec_instr),
        .wb_data      (wb_data),
        .wb_en        (wb_en),
        .branch_taken (branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] r3(input logic [7:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb);
        return {op, rd, ra, rb, 9'd0};
    endfunction

    function automatic logic [31:0] ri(input logic [7:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [13:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic vec_t mk(input bit rst, input bit fv, input logic [31:0] instr,
                                input bit stall, input bit br, input bit wen,
                                input logic [31:0] wdata, input bit er,
                                input logic [7:0] eop, input logic [31:0] ev1,
                                input logic [31:0] ev2);
        vec_t v;
        v.rst = rst; v.fv = fv; v.instr = instr; v.stall = stall; v.br = br;
        v.wen = wen; v.wdata = wdata; v.e_ready = er; v.e_op = eop;
        v.e_v1 = ev1; v.e_v2 = ev2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        reset_c      = v.rst;
        fetch_valid  = v.fv;
        fetch_instr  = v.instr;
        stall_alu    = v.stall;
        branch_taken = v.br;
        wb_en        = v.wen;
        wb_data      = v.wdata;
        #1;
        check($sformatf("%s ready", tag), {31'd0, decode_ready}, {31'd0, v.e_ready});
        @(posedge clock);
        #1;
        check($sformatf("%s dec_instr", tag), {24'd0, dec_instr}, {24'd0, v.e_op});
        check($sformatf("%s dec_val1", tag), dec_val1, v.e_v1);
        check($sformatf("%s dec_val2", tag), dec_val2, v.e_v2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;

        // Reset, then preload R1=5, R2=7 through the writeback path.
        vt.push_back(mk(0,0,32'h0,0,0,0,32'h0,           0,8'hFF,32'h0,32'h0));
        vt.push_back(mk(0,0,32'h0,0,0,0,32'h0,           0,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h00,1,0,0),0,0,0,32'h0, 1,8'h00,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h00,2,0,0),0,0,0,32'h0, 1,8'h00,32'h0,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,1,32'd5,           1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,1,32'd7,           1,8'hFF,32'h0,32'h0));
        // ADD R3,R1,R2
        vt.push_back(mk(1,1,r3(8'h00,3,1,2),0,0,0,32'h0, 1,8'h00,32'd5,32'd7));
        // ADD R4 then dependent SUB R5,R4,R1: one bubble, then bypass (R3 <- 12 meanwhile)
        vt.push_back(mk(1,1,r3(8'h00,4,1,2),0,0,0,32'h0, 1,8'h00,32'd5,32'd7));
        vt.push_back(mk(1,1,r3(8'h01,5,4,1),0,0,1,32'd12,0,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h01,5,4,1),0,0,1,32'd100,1,8'h01,32'd100,32'd5));
        // MEM 0x12 R7,R3,imm=0x3FFF; its "result" must not reach R7
        vt.push_back(mk(1,1,ri(8'h12,7,3,14'h3FFF),0,0,0,32'h0, 1,8'h12,32'd12,32'hFFFF_FFFF));
        vt.push_back(mk(1,0,32'h0,0,0,1,32'h55,          1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,1,32'hBAD,         1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h00,8,7,5),0,0,0,32'h0, 1,8'h00,32'h0,32'h55));
        // MEM 0x1F with positive immediate
        vt.push_back(mk(1,1,ri(8'h1F,0,1,14'h1FFF),0,0,0,32'h0, 1,8'h1F,32'd5,32'h1FFF));
        // ADD R0 (R8 <- 0x88 lands), illegal opcode, then write 0xDEAD to R0
        vt.push_back(mk(1,1,r3(8'h00,0,2,2),0,0,1,32'h88,1,8'h00,32'd7,32'd7));
        vt.push_back(mk(1,1,r3(8'h40,1,2,3),0,0,0,32'h0, 1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h00,1,0,0),0,0,1,32'hDEAD,1,8'h00,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h00,9,0,8),0,0,0,32'h0, 1,8'h00,32'h0,32'h88));
        vt.push_back(mk(1,0,32'h0,0,0,0,32'h0,           1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,0,32'h0,           1,8'hFF,32'h0,32'h0));
        // Distance-2 dependent: no bubble, bypass supplies R10
        vt.push_back(mk(1,1,r3(8'h00,10,1,1),0,0,0,32'h0,1,8'h00,32'd5,32'd5));
        vt.push_back(mk(1,1,r3(8'h00,11,2,2),0,0,0,32'h0,1,8'h00,32'd7,32'd7));
        vt.push_back(mk(1,1,r3(8'h00,12,10,0),0,0,1,32'h1234,1,8'h00,32'h1234,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,1,32'h77,          1,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,0,32'h0,0,0,0,32'h0,           1,8'hFF,32'h0,32'h0));
        // rb hazard on BEQ, then JUMP (val2 = 0)
        vt.push_back(mk(1,1,r3(8'h00,13,11,10),0,0,0,32'h0,1,8'h00,32'h77,32'h1234));
        vt.push_back(mk(1,1,r3(8'h30,0,1,13),0,0,0,32'h0,0,8'hFF,32'h0,32'h0));
        vt.push_back(mk(1,1,r3(8'h30,0,1,13),0,0,1,32'h99,1,8'h30,32'd5,32'h99));
        vt.push_back(mk(1,1,r3(8'h31,0,2,13),0,0,0,32'h0,1,8'h31,32'd7,32'h0));

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], $sformatf("v%0d", i));
        end

        // Redirect while ADD R6 is on the outputs; the fetched dependent is
        // consumed despite the hazard, and R6's wrong-path result is dropped.
        apply(mk(1,1,r3(8'h00,6,1,2),0,0,0,32'h0, 1,8'h00,32'd5,32'd7), "br_add");
        apply(mk(1,1,r3(8'h00,7,6,6),0,1,0,32'h0, 1,8'hFF,32'h0,32'h0), "br_taken");
        apply(mk(1,1,r3(8'h00,14,6,0),0,0,1,32'h666,1,8'h00,32'h0,32'h0), "br_wrongres");
        apply(mk(1,0,32'h0,0,0,0,32'h0,           1,8'hFF,32'h0,32'h0), "br_idle");
        apply(mk(1,1,r3(8'h00,15,6,0),0,0,0,32'h0, 1,8'h00,32'h0,32'h0), "br_r6");

        // ALU stall for 3 cycles: outputs held, ready low, R15 writeback lands;
        // a redirect during the stall is overridden by the stall.
        apply(mk(1,1,r3(8'h00,16,1,2),0,0,0,32'h0, 1,8'h00,32'd5,32'd7), "st_pre");
        apply(mk(1,1,r3(8'h00,17,2,2),1,0,1,32'hF15,0,8'h00,32'd5,32'd7), "st_1");
        apply(mk(1,1,r3(8'h00,17,2,2),1,0,0,32'h0, 0,8'h00,32'd5,32'd7), "st_2");
        apply(mk(1,1,r3(8'h00,17,2,2),1,1,0,32'h0, 0,8'h00,32'd5,32'd7), "st_3");
        apply(mk(1,1,r3(8'h00,17,15,2),0,0,0,32'h0,1,8'h00,32'hF15,32'd7), "st_post");

        // Reset mid-stream: pending write suppressed, registers cleared.
        apply(mk(0,1,r3(8'h00,18,1,1),0,0,1,32'hAAA,0,8'hFF,32'h0,32'h0), "rst_mid");
        apply(mk(1,1,r3(8'h00,19,15,1),0,0,0,32'h0,1,8'h00,32'h0,32'h0), "rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
